// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register library.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    function automatic int unsigned usr_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_frame_cnt.sv
// Frame counter: counts shifts modulo WIDTH and pulses frame_done on the wrap.
module usr_frame_cnt
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          step,
    input  logic                          clear,
    output logic [usr_cnt_w(WIDTH)-1:0]   shift_cnt,
    output logic                          frame_done
);

    localparam int unsigned        CW   = usr_cnt_w(WIDTH);
    localparam logic [CW-1:0]      LAST = CW'(WIDTH - 1);

    // en is needed on its own so an enabled HOLD drops the pulse while a stall stretches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            shift_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (step) begin
            if (shift_cnt == LAST) begin
                shift_cnt  <= '0;
                frame_done <= 1'b1;
            end else begin
                shift_cnt  <= shift_cnt + 1'b1;
                frame_done <= 1'b0;
            end
        end else if (en) begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with frame counter.
// Optional rotate mode is enabled by defining USR_ROTATE_EN.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic                          sin_msb,
    input  logic                          sin_lsb,
    input  logic [WIDTH-1:0]              pin,
`ifdef USR_ROTATE_EN
    input  logic                          rot,
`endif
    output logic [WIDTH-1:0]              q,
    output logic                          sout_lsb,
    output logic                          sout_msb,
    output logic [usr_cnt_w(WIDTH)-1:0]   shift_cnt,
    output logic                          frame_done
);

    usr_mode_t        op;
    logic             msb_in;
    logic             lsb_in;
    logic [WIDTH-1:0] q_next;

    assign op = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
    assign msb_in = rot ? q[0]       : sin_msb;
    assign lsb_in = rot ? q[WIDTH-1] : sin_lsb;
`else
    assign msb_in = sin_msb;
    assign lsb_in = sin_lsb;
`endif

    always_comb begin
        q_next = q;
        case (op)
            USR_SHR:  q_next = {msb_in, q[WIDTH-1:1]};
            USR_SHL:  q_next = {q[WIDTH-2:0], lsb_in};
            USR_LOAD: q_next = pin;
            default:  q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

    usr_frame_cnt #(
        .WIDTH(WIDTH)
    ) u_frame_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .step       (en && (op == USR_SHR || op == USR_SHL)),
        .clear      (en && (op == USR_LOAD)),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8); rotate checks need USR_ROTATE_EN.
module tb_univ_shift_reg;

    localparam int unsigned W = 8;
`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic         sin_msb;
    logic         sin_lsb;
    logic [W-1:0] pin;
    logic         rot;
    logic [W-1:0] q;
    logic         sout_lsb;
    logic         sout_msb;
    logic [3:0]   shift_cnt;
    logic         frame_done;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    logic [7:0] m_q;
    int         m_cnt;
    logic       m_done;

    univ_shift_reg #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .sin_msb    (sin_msb),
        .sin_lsb    (sin_lsb),
        .pin        (pin),
`ifdef USR_ROTATE_EN
        .rot        (rot),
`endif
        .q          (q),
        .sout_lsb   (sout_lsb),
        .sout_msb   (sout_msb),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q    = '0;
        m_cnt  = 0;
        m_done = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle, push the expected post-edge state, then step to edge+1.
    task automatic apply(input logic e, input logic [1:0] m, input logic smsb,
                         input logic slsb, input logic [7:0] p, input logic r);
        en = e; mode = m; sin_msb = smsb; sin_lsb = slsb; pin = p; rot = r;
        if (e) begin
            if (m == 2'b11) begin
                m_q = p; m_cnt = 0; m_done = 1'b0;
            end else if (m == 2'b00) begin
                m_done = 1'b0;
            end else begin
                if (m == 2'b01) m_q = {(ROT && r) ? m_q[0] : smsb, m_q[7:1]};
                else            m_q = {m_q[6:0], (ROT && r) ? m_q[7] : slsb};
                if (m_cnt == 7) begin m_cnt = 0; m_done = 1'b1; end
                else begin m_cnt = m_cnt + 1; m_done = 1'b0; end
            end
        end
        sb.push_back('{q: m_q, cnt: 4'(m_cnt), done: m_done});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t x;
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; sin_msb = 1'b0; sin_lsb = 1'b0;
        pin = '0; rot = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({q, shift_cnt, frame_done} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset: q=%h cnt=%0d done=%b, expected 00/0/0", q, shift_cnt, frame_done);
        end
        rst_n = 1'b1;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
        x = sb.pop_front();
        vectors++;
        if (q !== 8'hA5 || shift_cnt !== 4'd0 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL load: q=%h cnt=%0d done=%b, expected a5/0/0", q, shift_cnt, frame_done);
        end
    endtask

    task automatic test_serialise();
        exp_t       x;
        logic [7:0] pat = 8'hA5;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sout_lsb !== pat[i] || sout_msb !== q[7]) begin
                miscompares++;
                $display("FAIL serialise_sout[%0d]: lsb=%b msb=%b, expected lsb=%b msb=%b", i, sout_lsb, sout_msb, pat[i], q[7]);
            end
            apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x || frame_done !== (i == 7)) begin
                miscompares++;
                $display("FAIL serialise[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
        vectors++;
        if (q !== 8'h00) begin
            miscompares++;
            $display("FAIL serialise_final: q=%h, expected 00", q);
        end
    endtask

    task automatic test_deserialise();
        exp_t       x;
        logic [7:0] bits  = 8'b1101_0011; // bit i is the i-th serial input
        int         dones = 0;
        logic [3:0] held;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b10, 1'b0, bits[i], 8'h00, 1'b0);
            x = sb.pop_front();
            dones += int'(frame_done);
            vectors++;
            if ({q, shift_cnt, frame_done} !== x) begin
                miscompares++;
                $display("FAIL deser[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
            if (i == 1 || i == 3 || i == 5) begin
                held = shift_cnt;
                apply(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b0);
                x = sb.pop_front();
                dones += int'(frame_done);
                vectors++;
                if ({q, shift_cnt, frame_done} !== x || shift_cnt !== held) begin
                    miscompares++;
                    $display("FAIL deser_stall[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
                end
            end
        end
        vectors++;
        if (q !== 8'hCB || dones != 1) begin
            miscompares++;
            $display("FAIL deser_final: q=%h dones=%0d, expected q=cb dones=1", q, dones);
        end
    endtask

    task automatic test_abort_and_stretch();
        exp_t x;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 8'h00, 1'b0);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x) begin
                miscompares++;
                $display("FAIL abort_pre[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
        x = sb.pop_front();
        vectors++;
        if (q !== 8'h3C || shift_cnt !== 4'd0 || frame_done !== 1'b0 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL abort_load: q=%h cnt=%0d done=%b, expected 3c/0/0", q, shift_cnt, frame_done);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x || frame_done !== (i == 7)) begin
                miscompares++;
                $display("FAIL abort_post[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
        // A stall keeps the pulse high; an enabled HOLD then clears it.
        apply(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
        x = sb.pop_front();
        vectors++;
        if (frame_done !== 1'b1 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL stretch: done=%b cnt=%0d, expected done=1 cnt=0", frame_done, shift_cnt);
        end
        apply(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        x = sb.pop_front();
        vectors++;
        if (frame_done !== 1'b0 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL hold_clear: done=%b q=%h, expected done=0 q=%h", frame_done, q, x.q);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 2'b01, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x || frame_done !== (i == 7 || i == 15)) begin
                miscompares++;
                $display("FAIL b2b[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t x;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
            void'(sb.pop_front());
        end
        vectors++;
        if (q !== 8'h0F || shift_cnt !== 4'd4) begin
            miscompares++;
            $display("FAIL areset_pre: q=%h cnt=%0d, expected 0f/4", q, shift_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({q, shift_cnt, frame_done} !== 13'd0) begin
            miscompares++;
            $display("FAIL areset: q=%h cnt=%0d done=%b, expected 00/0/0", q, shift_cnt, frame_done);
        end
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x || frame_done !== (i == 7)) begin
                miscompares++;
                $display("FAIL areset_post[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        exp_t x;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0);
        void'(sb.pop_front());
        apply(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1);
        x = sb.pop_front();
        vectors++;
        if (q !== 8'h03 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL rot_shl: q=%h, expected 03", q);
        end
        apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
        void'(sb.pop_front());
        apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
        x = sb.pop_front();
        vectors++;
        if (q !== 8'hC0 || {q, shift_cnt, frame_done} !== x) begin
            miscompares++;
            $display("FAIL rot_shr: q=%h, expected c0", q);
        end
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1);
            x = sb.pop_front();
            vectors++;
            if ({q, shift_cnt, frame_done} !== x) begin
                miscompares++;
                $display("FAIL rot8[%0d]: q=%h cnt=%0d done=%b, expected q=%h cnt=%0d done=%b", i, q, shift_cnt, frame_done, x.q, x.cnt, x.done);
            end
        end
        vectors++;
        if (q !== 8'h81 || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL rot8_final: q=%h done=%b, expected 81/1", q, frame_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_serialise();
        test_deserialise();
        test_abort_and_stretch();
        test_back_to_back();
        test_async_reset();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
